boe_feeder: RTL and testbench

Upstream stage of the BOE scoring block (the unit that takes `data_num`/`data_in` and returns min, sum and the descending sort over `result`). It accepts bytes from a valid/ready source, groups them into sets of 1–6, and replays each group gap-free on `data_num`/`data_in` in the exact slot cadence BOE requires.

BOE has no enable and consumes `data_in` on every cycle of its receive phase. The feeder therefore owns BOE's active-high reset, `boe_rst`. It holds BOE in reset whenever no complete group is available at a slot boundary.

---
 rtl/boe_feeder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_boe_feeder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/boe_feeder.sv
// boe_feeder: upstream feeder for the BOE scoring block.
// Collects bytes from a valid/ready source into groups of 1..MAXN, then
// replays each group on data_num/data_in in BOE's slot cadence
// (N data cycles followed by N+2 idle cycles). It holds BOE in reset
// (boe_rst) whenever no complete group is ready at a slot boundary.
// Build option: define BOE_FEEDER_PINGPONG_EN for two fill banks, so the
// next group can fill while the current one streams. The default build
// uses a single bank.

// One group buffer: byte storage plus full flag and closed length.
module boe_feeder_bank #(
    parameter int DW   = 8,
    parameter int MAXN = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [2:0]                wr_idx,
    input  logic [DW-1:0]             wr_data,
    input  logic                      close,
    input  logic                      free,
    output logic                      full,
    output logic [2:0]                len,
    output logic [MAXN-1:0][DW-1:0]   bytes
);

    // Byte storage, written at the fill index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bytes <= '0;
        else if (wr_en)
            bytes[wr_idx] <= wr_data;
    end

    // Full flag and length: set on closure, cleared once streamed out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            len  <= 3'd0;
        end else if (close) begin
            full <= 1'b1;
            len  <= wr_idx + 3'd1;
        end else if (free) begin
            full <= 1'b0;
        end
    end

endmodule

module boe_feeder #(
    parameter int DW   = 8,
    parameter int MAXN = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic [2:0]    data_num,
    output logic [DW-1:0] data_in,
    output logic          boe_rst,
    output logic          launch,
    output logic          underrun
);

`ifdef BOE_FEEDER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    // Bank pointers only advance when there is a second bank to go to.
    localparam logic PTR_STEP = (NB == 2);

    typedef enum logic [1:0] {HOLD, STREAM, WAIT} state_t;

    state_t state, state_nx;

    // Fill side
    logic [2:0] wr_idx;
    logic       wptr, wptr_nx;
    logic       accept, close;

    // Read side
    logic       rptr;
    logic [2:0] rd_idx, rd_nx, rd_p1;
    logic [2:0] wcnt, cnt_nx;
    logic [2:0] cur_len, len_nx;
    logic       last_byte, expire, avail, start, free_cur;
    logic [2:0] av_len;
    logic [DW-1:0] av_b0;

    // Registered-output next values
    logic [2:0]    num_nx;
    logic [DW-1:0] din_nx;
    logic          rst_nx, und_nx, rdy_nx;
    logic [1:0]    full_nx;

    // Bank views (two slots; the second is tied off in the single-bank build)
    logic [1:0]                      bk_full;
    logic [1:0][2:0]                 bk_len;
    logic [1:0][MAXN-1:0][DW-1:0]    bk_bytes;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_bank
            if (g < NB) begin : g_on
                boe_feeder_bank #(.DW(DW), .MAXN(MAXN)) u_bank (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .wr_en   (accept && (wptr == 1'(g))),
                    .wr_idx  (wr_idx),
                    .wr_data (in_data),
                    .close   (close && (wptr == 1'(g))),
                    .free    (free_cur && (rptr == 1'(g))),
                    .full    (bk_full[g]),
                    .len     (bk_len[g]),
                    .bytes   (bk_bytes[g])
                );
            end else begin : g_off
                assign bk_full[g]  = 1'b0;
                assign bk_len[g]   = 3'd0;
                assign bk_bytes[g] = '0;
            end
        end
    endgenerate

    assign accept = in_valid & in_ready;
    assign close  = accept & (in_last | (wr_idx == 3'(MAXN - 1)));

    // A group closing on this very edge is already eligible for the slot;
    // its length and (for 1-byte groups) its first byte bypass the bank.
    assign avail  = bk_full[rptr] | (close & (wptr == rptr));
    assign av_len = bk_full[rptr] ? bk_len[rptr] : wr_idx + 3'd1;
    assign av_b0  = (!bk_full[rptr] && (wr_idx == 3'd0)) ? in_data
                                                          : bk_bytes[rptr][0];

    assign last_byte = (rd_idx == cur_len - 3'd1);
    assign expire    = (wcnt == cur_len + 3'd1);
    assign rd_p1     = rd_idx + 3'd1;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= HOLD;
        else
            state <= state_nx;
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            HOLD:    if (avail) state_nx = STREAM;
            STREAM:  if (last_byte) state_nx = WAIT;
            WAIT:    if (expire) state_nx = avail ? STREAM : HOLD;
            default: state_nx = HOLD;
        endcase
    end

    // FSM output logic: next values for the registered outputs and read side.
    always_comb begin
        start    = 1'b0;
        free_cur = 1'b0;
        und_nx   = 1'b0;
        rst_nx   = 1'b0;
        num_nx   = 3'd0;
        din_nx   = '0;
        rd_nx    = rd_idx;
        cnt_nx   = wcnt;
        len_nx   = cur_len;
        case (state)
            HOLD: begin
                start  = avail;
                rst_nx = ~avail;
            end
            STREAM: begin
                if (last_byte) begin
                    free_cur = 1'b1;
                    cnt_nx   = 3'd0;
                end else begin
                    rd_nx  = rd_p1;
                    din_nx = bk_bytes[rptr][rd_p1];
                end
            end
            WAIT: begin
                if (expire) begin
                    start  = avail;
                    und_nx = ~avail;
                end else begin
                    cnt_nx = wcnt + 3'd1;
                end
            end
            default: rst_nx = 1'b1;
        endcase
        if (start) begin
            num_nx = av_len;
            din_nx = av_b0;
            rd_nx  = 3'd0;
            len_nx = av_len;
        end
    end

    // in_ready looks ahead at bank occupancy after this edge's close/free.
    always_comb begin
        full_nx = bk_full;
        if (close)
            full_nx[wptr] = 1'b1;
        if (free_cur)
            full_nx[rptr] = 1'b0;
        wptr_nx = close ? (wptr ^ PTR_STEP) : wptr;
        rdy_nx  = ~full_nx[wptr_nx];
    end

    // Fill index and bank pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= 3'd0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
        end else begin
            if (accept)
                wr_idx <= close ? 3'd0 : wr_idx + 3'd1;
            wptr <= wptr_nx;
            if (free_cur)
                rptr <= rptr ^ PTR_STEP;
        end
    end

    // Read index, WAIT counter and current group length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx  <= 3'd0;
            wcnt    <= 3'd0;
            cur_len <= 3'd0;
        end else begin
            rd_idx  <= rd_nx;
            wcnt    <= cnt_nx;
            cur_len <= len_nx;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b1;
            data_num <= 3'd0;
            data_in  <= '0;
            boe_rst  <= 1'b1;
            launch   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            in_ready <= rdy_nx;
            data_num <= num_nx;
            data_in  <= din_nx;
            boe_rst  <= rst_nx;
            launch   <= start;
            underrun <= und_nx;
        end
    end

endmodule

// File: tb/tb_boe_feeder.sv
// Bench for boe_feeder: directed steps plus random groups, every cycle
// compared against a slot-timeline model of the feeder.
module tb_boe_feeder;

`ifdef BOE_FEEDER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_last;
    logic [7:0] in_data;
    logic       in_ready;
    logic [2:0] data_num;
    logic [7:0] data_in;
    logic       boe_rst, launch, underrun;

    boe_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .data_num(data_num), .data_in(data_in),
        .boe_rst(boe_rst), .launch(launch), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: groups queue in closure order; an active group
    // launched at edge L with length N shows its bytes on edges L..L+N-1,
    // zeros until L+2N+1, and decides the next slot at edge L+2N+2.
    int         t = 0;
    bit         m_act;
    int         m_L, m_N;
    logic [7:0] m_cur [6];
    logic [7:0] m_fill[$];
    logic [7:0] m_qb[$];
    int         m_ql[$];
    logic [2:0] e_num;
    logic [7:0] e_din;
    logic       e_rst, e_launch, e_und, e_rdy;

    // Observation records
    int         lt[$];
    int         ut[$];
    int         b2b_bad;
    int         cap_rem;
    logic [7:0] sent[$];
    logic [7:0] got[$];

    task automatic model_reset();
        m_act = 0; m_L = 0; m_N = 0;
        m_fill.delete(); m_qb.delete(); m_ql.delete();
        e_num = 3'd0; e_din = 8'h00; e_rst = 1'b1;
        e_launch = 1'b0; e_und = 1'b0; e_rdy = 1'b1;
        cap_rem = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic l, output logic acc);
        int dd, occ;
        bit go;
        acc = v && e_rdy;
        if (acc) begin
            m_fill.push_back(d);
            if (l || m_fill.size() == 6) begin
                m_ql.push_back(m_fill.size());
                foreach (m_fill[i]) m_qb.push_back(m_fill[i]);
                m_fill.delete();
            end
        end
        e_num = 3'd0; e_din = 8'h00; e_launch = 1'b0; e_und = 1'b0;
        go = 0;
        if (m_act) begin
            dd = t - m_L;
            e_rst = 1'b0;
            if (dd < m_N)
                e_din = m_cur[dd];
            else if (dd == 2 * m_N + 2) begin
                if (m_ql.size() > 0) go = 1;
                else begin e_und = 1'b1; m_act = 0; end
            end
        end else begin
            if (m_ql.size() > 0) go = 1;
            else e_rst = 1'b1;
        end
        if (go) begin
            m_N = m_ql.pop_front();
            for (int i = 0; i < m_N; i++) m_cur[i] = m_qb.pop_front();
            m_L = t; m_act = 1;
            e_num = 3'(m_N); e_din = m_cur[0]; e_launch = 1'b1; e_rst = 1'b0;
        end
        occ = m_ql.size() + ((m_act && (t - m_L) < m_N) ? 1 : 0);
        e_rdy = (occ < NB);
        t++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", {7'd0, in_ready}, {7'd0, e_rdy});
        chk("data_num", {5'd0, data_num}, {5'd0, e_num});
        chk("data_in",  data_in, e_din);
        chk("boe_rst",  {7'd0, boe_rst},  {7'd0, e_rst});
        chk("launch",   {7'd0, launch},   {7'd0, e_launch});
        chk("underrun", {7'd0, underrun}, {7'd0, e_und});
        if (launch === 1'b1) begin lt.push_back(t); cap_rem = int'(data_num); end
        if (underrun === 1'b1) ut.push_back(t);
        if (lt.size() == 1 && (boe_rst === 1'b1 || underrun === 1'b1)) b2b_bad++;
        if (cap_rem > 0) begin got.push_back(data_in); cap_rem--; end
    endtask

    task automatic tick(input logic v, input logic [7:0] d, input logic l, output logic acc);
        in_valid = v; in_data = d; in_last = l;
        @(posedge clk);
        model_edge(v, d, l, acc);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) tick(1'b0, 8'h00, 1'b0, a);
    endtask

    // Holds valid/data until accepted, bounded.
    task automatic send(input logic [7:0] d, input logic l);
        logic a;
        a = 1'b0;
        for (int k = 0; k < 200 && !a; k++) tick(1'b1, d, l, a);
        if (a) sent.push_back(d);
        else begin
            vectors++; miscompares++;
            $error("FAIL send_timeout: byte %0h not accepted in 200 cycles", d);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic lst;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        model_reset();
        #12;
        check_all();                                   // reset values
        @(negedge clk) rst_n = 1'b1;
        idle(3);

        // Single group 5,3,9
        send(8'd5, 1'b0); send(8'd3, 1'b0); send(8'd9, 1'b1);
        idle(12);

        // Auto-close at 6: bytes 1..7, then close the second group
        for (int i = 1; i <= 7; i++) send(8'(i), 1'b0);
        send(8'd8, 1'b1);
        idle(25);

        // Back-to-back 2-byte groups
        lt.delete(); ut.delete(); b2b_bad = 0;
        send(8'hA1, 1'b0); send(8'hA2, 1'b1);
        send(8'hB1, 1'b0); send(8'hB2, 1'b1);
        idle(16);
        chk_i("b2b_launch_gap", (lt.size() >= 2) ? lt[1] - lt[0] : -1, 6);
        chk_i("b2b_no_gap_events", b2b_bad, 0);

        // Underrun with a 1-byte group, relaunch 10 cycles later
        lt.delete(); ut.delete();
        send(8'h77, 1'b1);
        idle(10);
        send(8'h78, 1'b1);
        idle(10);
        chk_i("underrun_delay", (lt.size() >= 1 && ut.size() >= 1) ? ut[0] - lt[0] : -1, 4);
        chk_i("relaunch_count", lt.size(), 2);

        // Reset during byte 2 of a 4-byte group
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        idle(2);
        chk("mid_byte2", data_in, 8'h33);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst_n = 1'b1;
        idle(10);

        // Backpressure with random groups and gaps
        sent.delete(); got.delete();
        for (int gi = 0; gi < 20; gi++) begin
            n = $urandom_range(1, 6);
            for (int b = 0; b < n; b++) begin
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
                lst = (b == n - 1) && !(n == 6 && $urandom_range(0, 1) == 0);
                send(8'($urandom_range(0, 255)), lst);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 12));
        end
        idle(40);
        chk_i("sb_count", got.size(), sent.size());
        for (int i = 0; i < sent.size() && i < got.size(); i++)
            chk("sb_byte", got[i], sent[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
